sampling_strobe_gen: RTL and testbench

Programmable sampling-strobe generator. Runs in the fundamental 50 MHz domain and produces the `sampling_clk` square wave and single-cycle `strobe` that pace the test environment and the DUT sampling points. Configurable period, start offset and burst length. Supports start/stop control and a ready/valid configuration handshake.

---
 rtl/sampling_strobe_gen.sv | 211 +++++++++++++++++++++
 tb/tb_sampling_strobe_gen.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sampling_strobe_gen.sv
`default_nettype none
// ============================================================================
// Module   : sampling_strobe_gen
// Brief    : Programmable sampling-strobe generator. Produces a single-cycle
//            strobe and a square-wave sampling_clk with configurable period,
//            start offset and burst length. Start/stop run control plus a
//            ready/valid configuration write port.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            cfg_valid/cfg_ready - configuration write handshake
//            cfg_period/offset/burst - configuration values
//            start, stop         - run control
//            sampling_clk, strobe, busy, done, strobe_cnt - registered outputs
// Revision : 1.0 - initial release
// ============================================================================
module sampling_strobe_gen #(
    parameter int CNT_WIDTH   = 16,
    parameter int BURST_WIDTH = 8,
    parameter int DEF_PERIOD  = 500
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [CNT_WIDTH-1:0]   cfg_period,
    input  logic [CNT_WIDTH-1:0]   cfg_offset,
    input  logic [BURST_WIDTH-1:0] cfg_burst,
    input  logic                   start,
    input  logic                   stop,
    output logic                   sampling_clk,
    output logic                   strobe,
    output logic                   busy,
    output logic                   done,
    output logic [BURST_WIDTH-1:0] strobe_cnt
);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_offset = 2'd1;
    localparam logic [1:0] c_run    = 2'd2;

    localparam logic [CNT_WIDTH-1:0]   c_def_period = CNT_WIDTH'(DEF_PERIOD);
    localparam logic [CNT_WIDTH-1:0]   c_min_period = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0]   c_cnt_one    = CNT_WIDTH'(1);
    localparam logic [BURST_WIDTH-1:0] c_burst_one  = BURST_WIDTH'(1);

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;

    // Latched configuration
    logic [CNT_WIDTH-1:0]   r_cfg_period;
    logic [CNT_WIDTH-1:0]   r_cfg_offset;
    logic [BURST_WIDTH-1:0] r_cfg_burst;

    // Snapshot taken at start, so config writes never disturb a running burst
    logic [CNT_WIDTH-1:0]   r_run_period;
    logic [BURST_WIDTH-1:0] r_run_burst;

    logic [CNT_WIDTH-1:0]   r_off_cnt;
    logic [CNT_WIDTH-1:0]   r_phase;
    logic [BURST_WIDTH-1:0] r_strobe_cnt;

    logic                   r_cfg_ready;
    logic                   r_sclk;
    logic                   r_strobe;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_start_ok;
    logic                   w_last_phase;
    logic                   w_burst_end;
    logic [CNT_WIDTH-1:0]   w_period_act;
    logic [CNT_WIDTH-1:0]   w_off_cnt_nxt;
    logic [CNT_WIDTH-1:0]   w_phase_nxt;
    logic [BURST_WIDTH-1:0] w_cnt_nxt;
    logic                   w_strobe_nxt;
    logic                   w_sclk_nxt;
    logic                   w_done_nxt;

    // stop beats start when both arrive in IDLE
    assign w_start_ok   = (r_state == c_idle) && start && !stop;
    assign w_last_phase = (r_phase == (r_run_period - c_cnt_one));
    // The burst ends one full period after strobe number B
    assign w_burst_end  = (r_run_burst != '0) && (r_strobe_cnt == r_run_burst)
                          && w_last_phase;
    // On the start edge the run snapshot is not yet loaded
    assign w_period_act = w_start_ok ? r_cfg_period : r_run_period;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: begin
                if (w_start_ok) begin
                    w_state_nxt = (r_cfg_offset == '0) ? c_run : c_offset;
                end
            end
            c_offset: begin
                if (stop) begin
                    w_state_nxt = c_idle;
                end else if (r_off_cnt == c_cnt_one) begin
                    w_state_nxt = c_run;
                end
            end
            c_run: begin
                if (stop || w_burst_end) begin
                    w_state_nxt = c_idle;
                end
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / counter logic: next values of every registered output, so
    // that all outputs come straight from flops.
    // ------------------------------------------------------------------
    always_comb begin
        w_off_cnt_nxt = r_off_cnt;
        w_phase_nxt   = '0;
        w_cnt_nxt     = r_strobe_cnt;
        w_done_nxt    = 1'b0;

        if (w_start_ok) begin
            w_off_cnt_nxt = r_cfg_offset;
            w_cnt_nxt     = '0;
        end else if (r_state == c_offset) begin
            w_off_cnt_nxt = r_off_cnt - c_cnt_one;
        end

        // Phase 0 is the strobe cycle; it restarts on RUN entry and on wrap
        if (w_state_nxt == c_run) begin
            if ((r_state != c_run) || w_last_phase) begin
                w_phase_nxt = '0;
            end else begin
                w_phase_nxt = r_phase + c_cnt_one;
            end
        end

        w_strobe_nxt = (w_state_nxt == c_run) && (w_phase_nxt == '0);
        if (w_strobe_nxt) begin
            w_cnt_nxt = w_cnt_nxt + c_burst_one;
        end

        w_sclk_nxt = (w_state_nxt == c_run) && (w_phase_nxt < (w_period_act >> 1));

        if ((r_state == c_run) && !stop && w_burst_end) begin
            w_done_nxt = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_period <= c_def_period;
            r_cfg_offset <= '0;
            r_cfg_burst  <= '0;
            r_run_period <= c_def_period;
            r_run_burst  <= '0;
            r_off_cnt    <= '0;
            r_phase      <= '0;
            r_strobe_cnt <= '0;
            r_cfg_ready  <= 1'b1;
            r_sclk       <= 1'b0;
            r_strobe     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            // A run started on this same edge takes the old values
            if (cfg_valid && r_cfg_ready) begin
                r_cfg_period <= (cfg_period < c_min_period) ? c_min_period : cfg_period;
                r_cfg_offset <= cfg_offset;
                r_cfg_burst  <= cfg_burst;
            end
            if (w_start_ok) begin
                r_run_period <= r_cfg_period;
                r_run_burst  <= r_cfg_burst;
            end
            r_off_cnt    <= w_off_cnt_nxt;
            r_phase      <= w_phase_nxt;
            r_strobe_cnt <= w_cnt_nxt;
            r_cfg_ready  <= (w_state_nxt == c_idle);
            r_busy       <= (w_state_nxt != c_idle);
            r_sclk       <= w_sclk_nxt;
            r_strobe     <= w_strobe_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign cfg_ready    = r_cfg_ready;
    assign sampling_clk = r_sclk;
    assign strobe       = r_strobe;
    assign busy         = r_busy;
    assign done         = r_done;
    assign strobe_cnt   = r_strobe_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sampling_strobe_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sampling_strobe_gen
// Brief    : Self-checking bench for sampling_strobe_gen. Stimulus tasks keep
//            a run-level model (start edge, offset, period, burst, end edge)
//            and push expected strobe/done events into queues; a monitor
//            pops and compares them, plus busy/cfg_ready/sampling_clk.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sampling_strobe_gen;

    localparam int CNT_WIDTH   = 16;
    localparam int BURST_WIDTH = 8;
    localparam int DEF_PERIOD  = 500;
    localparam int BIG         = 32'h3fffffff;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   cfg_valid = 1'b0;
    logic                   cfg_ready;
    logic [CNT_WIDTH-1:0]   cfg_period = '0;
    logic [CNT_WIDTH-1:0]   cfg_offset = '0;
    logic [BURST_WIDTH-1:0] cfg_burst = '0;
    logic                   start = 1'b0;
    logic                   stop = 1'b0;
    logic                   sampling_clk;
    logic                   strobe;
    logic                   busy;
    logic                   done;
    logic [BURST_WIDTH-1:0] strobe_cnt;

    sampling_strobe_gen #(
        .CNT_WIDTH   (CNT_WIDTH),
        .BURST_WIDTH (BURST_WIDTH),
        .DEF_PERIOD  (DEF_PERIOD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_period   (cfg_period),
        .cfg_offset   (cfg_offset),
        .cfg_burst    (cfg_burst),
        .start        (start),
        .stop         (stop),
        .sampling_clk (sampling_clk),
        .strobe       (strobe),
        .busy         (busy),
        .done         (done),
        .strobe_cnt   (strobe_cnt)
    );

    always #10 clk = ~clk;

    // Edge counter: after edge e, cnt == e; "cycle" c is the one following edge c
    int cnt = 0;
    always @(posedge clk) cnt <= cnt + 1;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Latched configuration model
    int m_per = DEF_PERIOD;
    int m_off = 0;
    int m_burst = 0;

    // Current run model
    bit rs_valid = 1'b0;
    int rs = 0, rp = 2, ro = 0, rb = 0, rend = 0;

    typedef struct { int t; int n; } ev_t;
    ev_t sq[$];
    ev_t dq[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", nm, act, exp, cnt);
        end
    endtask

    function automatic int clamp(input int p);
        return (p < 2) ? 2 : p;
    endfunction

    function automatic bit busy_exp(input int c);
        return rs_valid && (c >= rs) && (c < rend);
    endfunction

    function automatic bit sclk_exp(input int c);
        if (!busy_exp(c) || (c < rs + ro)) return 1'b0;
        return ((c - rs - ro) % rp) < (rp / 2);
    endfunction

    // Strobes issued by the latest run, from its start and end edges
    function automatic int exp_cnt();
        int first, n;
        if (!rs_valid) return 0;
        first = rs + ro;
        if (rend <= first) return 0;
        n = (rend - first - 1) / rp + 1;
        if (rb > 0 && n > rb) n = rb;
        return n % 256;
    endfunction

    task automatic trim(input int s);
        while (sq.size() > 0 && sq[$].t >= s) void'(sq.pop_back());
        while (dq.size() > 0 && dq[$].t >= s) void'(dq.pop_back());
    endtask

    task automatic launch(input int s);
        int nmax;
        ev_t e;
        rs_valid = 1'b1;
        rs = s; rp = m_per; ro = m_off; rb = m_burst;
        rend = (rb > 0) ? (rs + ro + rb * rp) : BIG;
        nmax = (rb > 0) ? rb : 600;
        for (int n = 1; n <= nmax; n++) begin
            e.t = rs + ro + (n - 1) * rp;
            e.n = n % 256;
            sq.push_back(e);
        end
        if (rb > 0) begin
            e.t = rend; e.n = 0;
            dq.push_back(e);
        end
    endtask

    // One clock edge of stimulus; the model reacts to what the DUT must sample
    task automatic drive_edge(input bit w, input int p, input int o, input int b,
                              input bit st, input bit sp);
        int  c0, s;
        bit  idle;
        @(negedge clk);
        cfg_valid  = w;
        cfg_period = CNT_WIDTH'(p);
        cfg_offset = CNT_WIDTH'(o);
        cfg_burst  = BURST_WIDTH'(b);
        start      = st;
        stop       = sp;
        c0   = cnt;
        idle = !busy_exp(c0);
        s    = c0 + 1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
        if (sp && !idle) begin
            if (s < rend) rend = s;
            trim(s);
        end
        if (st && !sp && idle) launch(s);
        if (w && idle) begin
            m_per = clamp(p); m_off = o; m_burst = b;
        end
    endtask

    task automatic reset_edge();
        int s;
        @(negedge clk);
        rst = 1'b1;
        s = cnt + 1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        trim(s);
        if (s < rend) rend = s;
        rs_valid = 1'b0;
        m_per = DEF_PERIOD; m_off = 0; m_burst = 0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_run_end();
        int guard;
        guard = 0;
        while (busy_exp(cnt) && guard < 6000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 6000) begin
            total++; bad++;
            $display("FAIL run_end_timeout: got busy expected idle at edge %0d", cnt);
        end
        @(negedge clk);
    endtask

    // Monitor: per-cycle status checks and scoreboard pops
    always @(negedge clk) begin : mon
        int c;
        bit be;
        if (chk_en) begin
            c  = cnt;
            be = busy_exp(c);
            check("busy", 32'(busy), 32'(be));
            check("cfg_ready", 32'(cfg_ready), 32'(!be));
            check("sampling_clk", 32'(sampling_clk), 32'(sclk_exp(c)));
            check("strobe_done_excl", 32'(strobe & done), 32'd0);
            if (sq.size() > 0 && sq[0].t == c) begin
                check("strobe", 32'(strobe), 32'd1);
                check("strobe_cnt", 32'(strobe_cnt), 32'(sq[0].n));
                void'(sq.pop_front());
            end else begin
                check("strobe", 32'(strobe), 32'd0);
            end
            if (dq.size() > 0 && dq[0].t == c) begin
                check("done", 32'(done), 32'd1);
                void'(dq.pop_front());
            end else begin
                check("done", 32'(done), 32'd0);
            end
        end
    end

    initial begin
        int p, o, b;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_sampling_clk", 32'(sampling_clk), 32'd0);
        check("rst_strobe", 32'(strobe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_strobe_cnt", 32'(strobe_cnt), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Defaults: period 500, offset 0, continuous
        drive_edge(0, 0, 0, 0, 1, 0);
        idle_cycles(1100);
        drive_edge(0, 0, 0, 0, 0, 1);
        idle_cycles(1);
        check("default_cnt", 32'(strobe_cnt), 32'(exp_cnt()));

        // period 4, offset 3, burst 3
        drive_edge(1, 4, 3, 3, 0, 0);
        drive_edge(0, 0, 0, 0, 1, 0);
        wait_run_end();
        check("burst3_cnt", 32'(strobe_cnt), 32'd3);

        // period 1 clamps to 2; write+start same edge uses the old config
        drive_edge(1, 1, 0, 4, 0, 0);
        drive_edge(0, 0, 0, 0, 1, 0);
        wait_run_end();
        drive_edge(1, 10, 0, 2, 1, 0);
        wait_run_end();
        check("same_edge_cnt", 32'(strobe_cnt), 32'd4);
        drive_edge(0, 0, 0, 0, 1, 0);
        wait_run_end();
        check("new_cfg_cnt", 32'(strobe_cnt), 32'd2);

        // Continuous period 2: counter wraps past 255, then stop
        drive_edge(1, 2, 0, 0, 0, 0);
        drive_edge(0, 0, 0, 0, 1, 0);
        idle_cycles(530);
        drive_edge(0, 0, 0, 0, 0, 1);
        idle_cycles(2);
        check("wrap_cnt", 32'(strobe_cnt), 32'(exp_cnt()));

        // Config and start while busy are ignored; start+stop in IDLE stays IDLE
        drive_edge(1, 6, 2, 0, 0, 0);
        drive_edge(0, 0, 0, 0, 1, 0);
        idle_cycles(5);
        drive_edge(1, 3, 1, 1, 0, 0);
        drive_edge(0, 0, 0, 0, 1, 0);
        idle_cycles(9);
        drive_edge(0, 0, 0, 0, 0, 1);
        idle_cycles(2);
        drive_edge(0, 0, 0, 0, 1, 1);
        idle_cycles(4);
        check("startstop_idle", 32'(busy), 32'd0);
        drive_edge(0, 0, 0, 0, 1, 0);
        idle_cycles(20);
        drive_edge(0, 0, 0, 0, 0, 1);
        idle_cycles(1);
        check("ignored_cfg_cnt", 32'(strobe_cnt), 32'(exp_cnt()));

        // Reset mid-run restores offset 0 and period 500
        drive_edge(1, 4, 5, 0, 0, 0);
        drive_edge(0, 0, 0, 0, 1, 0);
        idle_cycles(12);
        reset_edge();
        check("midrst_cnt", 32'(strobe_cnt), 32'd0);
        idle_cycles(2);
        drive_edge(0, 0, 0, 0, 1, 0);
        idle_cycles(5);
        drive_edge(0, 0, 0, 0, 0, 1);
        idle_cycles(1);
        check("after_rst_cnt", 32'(strobe_cnt), 32'd1);

        // Randomized runs
        for (int it = 0; it < 40; it++) begin
            p = $urandom_range(0, 9);
            o = $urandom_range(0, 5);
            b = $urandom_range(0, 4);
            drive_edge(1, p, o, b, 0, 0);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(0, 2));
            drive_edge(0, 0, 0, 0, 1, ($urandom_range(0, 7) == 0));
            if (b == 0 || $urandom_range(0, 1) == 1) begin
                idle_cycles($urandom_range(0, 30));
                if ($urandom_range(0, 2) == 0)
                    drive_edge(1, $urandom_range(0, 9), $urandom_range(0, 5),
                               $urandom_range(0, 4), $urandom_range(0, 1), 0);
                drive_edge(0, 0, 0, 0, 0, 1);
            end
            wait_run_end();
            check("rand_cnt", 32'(strobe_cnt), 32'(exp_cnt()));
        end

        idle_cycles(3);
        check("strobe_queue_empty", 32'(sq.size()), 32'd0);
        check("done_queue_empty", 32'(dq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
